// File: rtl/ffra_dot_if.sv
// Operand-stream and result-stream handshake bundle for the ffra_dot sequencer.
interface ffra_dot_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_ovf;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data, res_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/ffra_dot.sv
// Dot-product sequencer feeding the ffra multiply-add core (bias + sum a_i*b_i, mod 2^16).
// Optional wrap detection is enabled by defining FFRA_DOT_OVF_EN.
module ffra_dot #(
  parameter int unsigned MAC_LAT = 1,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [15:0]      bias,
  ffra_dot_if.slave        bus,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic [15:0]      mac_ci,
  input  logic [15:0]      mac_o,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

  state_t           state;
  logic [15:0]      acc;
  logic [LEN_W-1:0] rem;
  logic [1:0]       wcnt;
  logic             capture;
  logic             last;

  always_comb begin
    capture = (state == WAIT) && (wcnt == 2'd0);
    last    = (rem == LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      rem           <= '0;
      wcnt          <= '0;
      mac_a         <= '0;
      mac_b         <= '0;
      mac_ci        <= '0;
      busy          <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc  <= bias;
            rem  <= cfg_len;
            busy <= 1'b1;
            if (cfg_len == '0) begin
              state         <= DONE;
              bus.res_valid <= 1'b1;
              bus.res_data  <= bias;
            end else begin
              state        <= RUN;
              bus.in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.in_valid && bus.in_ready) begin
            mac_a        <= bus.in_a;
            mac_b        <= bus.in_b;
            mac_ci       <= acc;
            wcnt         <= 2'(MAC_LAT);
            bus.in_ready <= 1'b0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (!capture) begin
            wcnt <= wcnt - 2'd1;
          end else begin
            acc <= mac_o;
            rem <= rem - LEN_W'(1);
            if (last) begin
              state         <= DONE;
              bus.res_valid <= 1'b1;
              bus.res_data  <= mac_o;
            end else begin
              state        <= RUN;
              bus.in_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FFRA_DOT_OVF_EN
  // a*b < 2^16, so a sum smaller than its ci input can only mean a wrap.
  logic ovf_flag;
  logic wrap;

  always_comb wrap = capture && (mac_o < mac_ci);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_flag    <= 1'b0;
      bus.res_ovf <= 1'b0;
    end else begin
      if (state == IDLE && start) ovf_flag <= 1'b0;
      else if (wrap)              ovf_flag <= 1'b1;
      if (capture && last)                      bus.res_ovf <= ovf_flag | wrap;
      else if (state == DONE && bus.res_ready)  bus.res_ovf <= 1'b0;
    end
  end
`else
  assign bus.res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ffra_dot.sv
// Directed self-checking bench for ffra_dot with a behavioural ffra core model.
module tb_ffra_dot;
  localparam int unsigned LAT = 1;
`ifdef FFRA_DOT_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  cfg_len;
  logic [15:0] bias;
  logic [7:0]  mac_a, mac_b;
  logic [15:0] mac_ci, mac_o;
  logic        busy;

  ffra_dot_if bus ();

  ffra_dot #(.MAC_LAT(LAT), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .bias(bias),
    .bus(bus), .mac_a(mac_a), .mac_b(mac_b), .mac_ci(mac_ci), .mac_o(mac_o),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural multiply-add core: o = a*b + ci, LAT register stages.
  logic [15:0] mac_sum;
  logic [15:0] stg [3];
  assign mac_sum = {8'd0, mac_a} * {8'd0, mac_b} + mac_ci;
  always_ff @(posedge clk) begin
    stg[0] <= mac_sum;
    stg[1] <= stg[0];
    stg[2] <= stg[1];
  end
  always_comb begin
    mac_o = mac_sum;
    for (int i = 1; i <= 3; i++) if (LAT == i) mac_o = stg[i-1];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [7:0] len);
    bias    = b;
    cfg_len = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
  endtask

  // Presents a pair and returns after its accept edge; w = idle cycles waited.
  task automatic feed(input logic [7:0] a, input logic [7:0] b, output int w);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!bus.in_ready) check("feed_timeout", 32'(bus.in_ready), 32'd1);
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int c;
    c = 0;
    while (!bus.res_valid && c < 50) begin
      tick();
      c++;
    end
    if (!bus.res_valid) check(tag, 32'(bus.res_valid), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_res_data"},  32'(bus.res_data),  32'd0);
    check({tag, "_res_ovf"},   32'(bus.res_ovf),   32'd0);
    check({tag, "_busy"},      32'(busy),          32'd0);
    check({tag, "_mac_a"},     32'(mac_a),         32'd0);
    check({tag, "_mac_b"},     32'(mac_b),         32'd0);
    check({tag, "_mac_ci"},    32'(mac_ci),        32'd0);
  endtask

  initial begin
    int w;
    int n;
    logic acc_now;
    logic [15:0] held;

    rst_n = 1'b0; start = 1'b0; cfg_len = '0; bias = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: basic sum 0 + 2*3 + 4*5 + 10*10 = 126
    do_start(16'h0000, 8'd3);
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    feed(8'd2, 8'd3, w);
    check("t1_wait0", 32'(w), 32'd0);
    check("t1_mac_a0", 32'(mac_a), 32'd2);
    check("t1_mac_b0", 32'(mac_b), 32'd3);
    check("t1_ci0", 32'(mac_ci), 32'd0);
    feed(8'd4, 8'd5, w);
    check("t1_gap1", 32'(w), 32'(LAT + 1));
    check("t1_ci1", 32'(mac_ci), 32'd6);
    feed(8'd10, 8'd10, w);
    check("t1_gap2", 32'(w), 32'(LAT + 1));
    check("t1_ci2", 32'(mac_ci), 32'd26);
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    check("t1_lat_early", 32'(bus.res_valid), 32'd0);
    tick();
    check("t1_valid", 32'(bus.res_valid), 32'd1);
    check("t1_data", 32'(bus.res_data), 32'd126);
    check("t1_ovf", 32'(bus.res_ovf), 32'd0);
    tick();
    check("t1_idle_valid", 32'(bus.res_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    bus.res_ready = 1'b0;

    // 2: wrap 0xFF00 + 255*255 = 0x1FD01 -> 0xFD01; 4: backpressure in DONE
    do_start(16'hFF00, 8'd1);
    feed(8'd255, 8'd255, w);
    bus.in_valid = 1'b0;
    wait_valid("t2_timeout");
    check("t2_data", 32'(bus.res_data), 32'hFD01);
    check("t2_ovf", 32'(bus.res_ovf), 32'(OVF_EXP));
    held = bus.res_data;
    for (int i = 0; i < 5; i++) begin
      start = ~start;
      cfg_len = 8'd0;
      bias = 16'h5555;
      tick();
      check("t4_valid", 32'(bus.res_valid), 32'd1);
      check("t4_data", 32'(bus.res_data), 32'(held));
      check("t4_in_ready", 32'(bus.in_ready), 32'd0);
      check("t4_ovf", 32'(bus.res_ovf), 32'(OVF_EXP));
    end
    start = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    start = 1'b0;
    bus.res_ready = 1'b0;
    check("t4_idle_valid", 32'(bus.res_valid), 32'd0);
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_idle_ovf", 32'(bus.res_ovf), 32'd0);
    tick();
    check("t4_still_idle", 32'(busy), 32'd0);

    // 3: zero length
    do_start(16'h1234, 8'd0);
    check("t3_valid", 32'(bus.res_valid), 32'd1);
    check("t3_data", 32'(bus.res_data), 32'h1234);
    check("t3_in_ready", 32'(bus.in_ready), 32'd0);
    check("t3_ovf", 32'(bus.res_ovf), 32'd0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("t3_idle_valid", 32'(bus.res_valid), 32'd0);
    check("t3_idle_in_ready", 32'(bus.in_ready), 32'd0);

    // 5: random input gaps, 7 + 4*(1*1) = 11
    do_start(16'd7, 8'd4);
    n = 0;
    for (int c = 0; c < 300 && !bus.res_valid; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a = 8'd1;
      bus.in_b = 8'd1;
      acc_now = bus.in_valid && bus.in_ready;
      tick();
      if (acc_now) begin
        check("t5_ci", 32'(mac_ci), 32'(7 + n));
        n++;
      end
    end
    bus.in_valid = 1'b0;
    check("t5_done", 32'(bus.res_valid), 32'd1);
    check("t5_accepts", 32'(n), 32'd4);
    check("t5_data", 32'(bus.res_data), 32'd11);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // 6: reset during WAIT, then fresh 3*3 run
    do_start(16'd5, 8'd2);
    feed(8'd3, 8'd3, w);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check_all_zero("t6_reset");
    rst_n = 1'b1;
    tick();
    do_start(16'd0, 8'd1);
    feed(8'd3, 8'd3, w);
    bus.in_valid = 1'b0;
    wait_valid("t6_timeout");
    check("t6_data", 32'(bus.res_data), 32'd9);
    check("t6_ovf", 32'(bus.res_ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
